// File: rtl/egress_mem_arbiter.sv
// Round-robin arbiter sharing the frame-memory read port among egress blocks.
// Each port holds one pending read; the granted port streams until end-of-frame or timeout.

module egress_req_slot #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              clr,
    output logic              pend,
    output logic [ADDR_W-1:0] pend_addr,
    output logic              ovf
);
    // A new start wins over a same-edge clear, so a back-to-back request is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_addr <= '0;
            ovf       <= 1'b0;
        end else if (start) begin
            if (pend && !clr) begin
                ovf <= 1'b1;
            end else begin
                pend      <= 1'b1;
                pend_addr <= addr;
            end
        end else if (clr) begin
            pend <= 1'b0;
        end
    end
endmodule

module egress_mem_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_BYTES = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                              switch_clk,
    input  logic                              switch_rst_n,
    input  logic [NUM_PORTS-1:0]              req_start_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr_i,
    input  logic [NUM_PORTS-1:0]              req_re_i,
    output logic [BLOCK_BYTES*DATA_WIDTH-1:0] frame_data_o,
    output logic [NUM_PORTS-1:0]              frame_valid_o,
    output logic [NUM_PORTS-1:0]              frame_end_o,
    output logic                              mem_start_o,
    output logic [ADDR_W-1:0]                 mem_start_addr_o,
    output logic                              mem_re_o,
    input  logic [BLOCK_BYTES*DATA_WIDTH-1:0] mem_frame_data_i,
    input  logic                              mem_frame_valid_i,
    input  logic                              mem_frame_end_i,
    output logic [$clog2(NUM_PORTS)-1:0]      grant_o,
    output logic                              busy_o,
    output logic [NUM_PORTS-1:0]              overflow_o,
    output logic                              timeout_o
);
    localparam int GW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_STREAM} state_t;

    state_t                            state;
    logic [GW-1:0]                     grant;
    logic [GW-1:0]                     last_grant;
    logic [GW-1:0]                     next_port;
    logic                              found;
    logic [CW-1:0]                     to_cnt;
    logic [NUM_PORTS-1:0]              pend;
    logic [NUM_PORTS-1:0]              clr;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  pend_addr;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        assign clr[g] = (state == ST_START) && (grant == GW'(g));
        egress_req_slot #(.ADDR_W(ADDR_W)) u_slot (
            .clk       (switch_clk),
            .rst_n     (switch_rst_n),
            .start     (req_start_i[g]),
            .addr      (req_addr_i[g*ADDR_W +: ADDR_W]),
            .clr       (clr[g]),
            .pend      (pend[g]),
            .pend_addr (pend_addr[g]),
            .ovf       (overflow_o[g])
        );
    end

    // First pending port after the last grant, wrapping; last_grant itself is checked last.
    always_comb begin
        found     = 1'b0;
        next_port = last_grant;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (!found && pend[idx]) begin
                found     = 1'b1;
                next_port = GW'(idx);
            end
        end
    end

    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_PORTS - 1);
            to_cnt     <= '0;
            timeout_o  <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant <= next_port;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    to_cnt <= '0;
                    state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (mem_frame_valid_i) begin
                        to_cnt <= '0;
                        if (mem_frame_end_i) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end
                    end else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        // Stalled frame is dropped; the port must re-request.
                        timeout_o  <= 1'b1;
                        last_grant <= grant;
                        to_cnt     <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_valid_o = '0;
        frame_end_o   = '0;
        if (state == ST_STREAM) begin
            frame_valid_o[grant] = mem_frame_valid_i;
            frame_end_o[grant]   = mem_frame_valid_i & mem_frame_end_i;
        end
    end

    assign mem_start_o      = (state == ST_START);
    assign mem_start_addr_o = pend_addr[grant];
    assign mem_re_o         = (state == ST_STREAM) && req_re_i[grant];
    assign frame_data_o     = mem_frame_data_i;
    assign grant_o          = grant;
    assign busy_o           = (state != ST_IDLE);
endmodule

// File: tb/tb_egress_mem_arbiter.sv
// Scoreboard bench for egress_mem_arbiter: expected grants and beats are queued
// as stimulus is driven and compared when the DUT presents them.

module tb_egress_mem_arbiter;
    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int BB = 4;
    localparam int TO = 8;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     req_start;
    logic [NP*AW-1:0]  req_addr;
    logic [NP-1:0]     req_re;
    logic [BB*DW-1:0]  frame_data;
    logic [NP-1:0]     frame_valid;
    logic [NP-1:0]     frame_end;
    logic              mem_start;
    logic [AW-1:0]     mem_start_addr;
    logic              mem_re;
    logic [BB*DW-1:0]  mem_data;
    logic              mem_valid;
    logic              mem_end;
    logic [1:0]        grant;
    logic              busy;
    logic [NP-1:0]     overflow;
    logic              timeout;

    egress_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_WIDTH(DW), .BLOCK_BYTES(BB), .TIMEOUT_CYC(TO)
    ) dut (
        .switch_clk       (clk),
        .switch_rst_n     (rst_n),
        .req_start_i      (req_start),
        .req_addr_i       (req_addr),
        .req_re_i         (req_re),
        .frame_data_o     (frame_data),
        .frame_valid_o    (frame_valid),
        .frame_end_o      (frame_end),
        .mem_start_o      (mem_start),
        .mem_start_addr_o (mem_start_addr),
        .mem_re_o         (mem_re),
        .mem_frame_data_i (mem_data),
        .mem_frame_valid_i(mem_valid),
        .mem_frame_end_i  (mem_end),
        .grant_o          (grant),
        .busy_o           (busy),
        .overflow_o       (overflow),
        .timeout_o        (timeout)
    );

    typedef struct { int port; logic [AW-1:0] addr; } start_t;
    typedef struct { logic [BB*DW-1:0] data; logic last; } beat_t;

    start_t sq[$];
    beat_t  bq[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     n_starts = 0;
    int     cur_port = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: every start and every delivered beat must match the head of its queue.
    start_t ms;
    beat_t  mb;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_start) begin
                n_starts++;
                if (sq.size() == 0) chk("unexp_start", 32'(mem_start), 0);
                else begin
                    ms = sq.pop_front();
                    chk("start_port", 32'(grant), ms.port);
                    chk("start_addr", 32'(mem_start_addr), 32'(ms.addr));
                    cur_port = ms.port;
                end
            end
            if (frame_valid != 0 || frame_end != 0) begin
                if (bq.size() == 0) chk("unexp_beat", 32'(frame_valid), 0);
                else begin
                    mb = bq.pop_front();
                    chk("beat_valid", 32'(frame_valid), 32'(1) << cur_port);
                    chk("beat_end", 32'(frame_end), mb.last ? (32'(1) << cur_port) : 0);
                    chk("beat_data", frame_data, mb.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] a, input bit exp);
        start_t s;
        req_start[p] = 1'b1;
        req_addr[p*AW +: AW] = a;
        if (exp) begin
            s.port = p;
            s.addr = a;
            sq.push_back(s);
        end
    endtask

    task automatic pulse();
        tick();
        req_start = '0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_start && n < 40);
        if (!mem_start) chk("start_wait", 32'(mem_start), 1);
        tick();
    endtask

    task automatic beat(input bit last, input bit exp);
        beat_t b;
        b.data = $urandom;
        b.last = last;
        mem_valid = 1'b1;
        mem_data  = b.data;
        mem_end   = last;
        if (exp) bq.push_back(b);
        tick();
        mem_valid = 1'b0;
        mem_end   = 1'b0;
    endtask

    task automatic serve(input int nb);
        for (int k = 0; k < nb; k++) beat(k == nb - 1, 1'b1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_mem_start", 32'(mem_start), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_fvalid", 32'(frame_valid), 0);
        chk("rst_fend", 32'(frame_end), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_overflow", 32'(overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        clk = 1'b0; rst_n = 1'b0;
        req_start = '0; req_addr = '0; req_re = '1;
        mem_data = '0; mem_valid = 1'b0; mem_end = 1'b0;
        repeat (3) tick();
        chk_reset_vals();
        rst_n = 1'b1;
        tick();

        // Single port 0 frame of 3 blocks.
        set_req(0, 12'h010, 1'b1);
        pulse();
        wait_start(n);
        chk("latency", n, 2);
        serve(3);
        chk("busy_after_end", 32'(busy), 0);

        rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Three simultaneous requests from a fresh round-robin pointer.
        set_req(0, 12'h100, 1'b1);
        set_req(1, 12'h200, 1'b1);
        set_req(2, 12'h300, 1'b1);
        pulse();
        wait_start(n);
        serve(2);
        for (int r = 0; r < 2; r++) begin
            wait_start(n);
            chk("grant_gap", n, 2);
            serve(2);
        end

        // Port 3 last, then 0 and 3 together: search wraps to port 0 first.
        set_req(3, 12'h333, 1'b1);
        pulse();
        wait_start(n);
        serve(1);
        set_req(0, 12'h0a0, 1'b1);
        set_req(3, 12'h3a0, 1'b1);
        pulse();
        wait_start(n);
        serve(1);
        wait_start(n);
        serve(1);

        // Re-request mid-frame is queued; a second one overflows and is discarded.
        set_req(1, 12'h080, 1'b1);
        pulse();
        wait_start(n);
        beat(1'b0, 1'b1);
        set_req(1, 12'h040, 1'b1);
        pulse();
        chk("ovf_none", 32'(overflow), 0);
        beat(1'b0, 1'b1);
        set_req(1, 12'h050, 1'b0);
        pulse();
        chk("ovf_set", 32'(overflow), 32'h2);
        beat(1'b1, 1'b1);
        wait_start(n);
        serve(1);

        // Stall on beat-ready, then a timeout with port 0 waiting.
        set_req(2, 12'h123, 1'b1);
        pulse();
        wait_start(n);
        req_re[2] = 1'b0;
        set_req(0, 12'h0aa, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_re", 32'(mem_re), 0);
            tick();
            req_start = '0;
        end
        req_re[2] = 1'b1;
        #1 chk("stall_release_re", 32'(mem_re), 1);
        beat(1'b0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout && n < 30);
        chk("timeout_cycles", n, 9);
        chk("timeout_idle", 32'(busy), 0);
        wait_start(n);
        chk("next_after_timeout", n, 1);
        chk("timeout_single", 32'(timeout), 0);
        serve(1);

        // Reset mid-stream with two ports pending: everything is dropped.
        set_req(1, 12'h111, 1'b1);
        pulse();
        wait_start(n);
        beat(1'b0, 1'b1);
        set_req(2, 12'h222, 1'b0);
        set_req(3, 12'h333, 1'b0);
        pulse();
        #2 rst_n = 1'b0;
        mem_valid = 1'b1;
        #1 chk_reset_vals();
        repeat (2) tick();
        rst_n = 1'b1;
        mem_valid = 1'b0;
        n0 = n_starts;
        repeat (10) tick();
        chk("post_reset_starts", n_starts - n0, 0);

        chk("sb_starts_left", sq.size(), 0);
        chk("sb_beats_left", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
